// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: sequential fetch, execute-stage redirects, and post-redirect squash window.
// Optional `EXEC_RETURN_EN: honour putPCback/execPCadded with priority over branch2_idex.
module pc_fetch_ctrl #(
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000,
  parameter int                  FLUSH_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch2_idex,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                putPCback,
  input  logic [PC_WIDTH-1:0] execPCadded,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_added,
  output logic                squash,
  output logic                fetch_valid,
  output logic                redirect_taken,
  output logic                busy
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] pc_added_reg;
  logic [2:0]          cnt_reg, cnt_next;
  logic                squash_reg, squash_next;
  logic                fetch_valid_reg;
  logic                redirect_reg, redirect_next;

  logic                req;
  logic [PC_WIDTH-1:0] req_target;

`ifdef EXEC_RETURN_EN
  // An exec return outranks a concurrent branch, which is dropped.
  always_comb begin
    req        = putPCback | branch2_idex;
    req_target = putPCback ? execPCadded : branch_target;
  end
`else
  logic unused_exec_return;
  assign unused_exec_return = putPCback ^ (^execPCadded);

  always_comb begin
    req        = branch2_idex;
    req_target = branch_target;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      pc_added_reg    <= RESET_PC + 1'b1;
      cnt_reg         <= 3'd0;
      squash_reg      <= 1'b0;
      fetch_valid_reg <= 1'b1;
      redirect_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pc_added_reg    <= pc_next + 1'b1;
      cnt_reg         <= cnt_next;
      squash_reg      <= squash_next;
      fetch_valid_reg <= ~squash_next;
      redirect_reg    <= redirect_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    cnt_next      = cnt_reg;
    squash_next   = squash_reg;
    redirect_next = 1'b0;
    case (state_reg)
      RUN: begin
        squash_next = 1'b0;
        // A redirect is taken even while stalled.
        if (req) begin
          pc_next       = req_target;
          cnt_next      = 3'(FLUSH_DEPTH);
          squash_next   = 1'b1;
          redirect_next = 1'b1;
          state_next    = SQUASH;
        end else if (!stall) begin
          pc_next = pc_added_reg;
        end
      end
      SQUASH: begin
        // Requests here come from squashed instructions and are ignored.
        if (!stall) begin
          pc_next  = pc_added_reg;
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            squash_next = 1'b0;
            state_next  = RUN;
          end
        end
      end
      default: begin
        state_next  = RUN;
        squash_next = 1'b0;
      end
    endcase
  end

  assign pc             = pc_reg;
  assign pc_added       = pc_added_reg;
  assign squash         = squash_reg;
  assign fetch_valid    = fetch_valid_reg;
  assign redirect_taken = redirect_reg;
  assign busy           = (state_reg == SQUASH);

endmodule
